// File: rtl/wisc_pkg.sv
// Shared types and defaults for the EX-stage flow sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wisc_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BR_EVAL  = 2'd1,
        RET_WAIT = 2'd2,
        FLUSH    = 2'd3
    } ex_flow_state_t;

    // Cycles flush is held after a redirect (younger instrs sit in IF and ID).
    localparam int FLUSH_CYCLES_DEF = 2;
    // RET_WAIT cycles tolerated without ret_wb before flagging an error.
    localparam int RET_TIMEOUT_DEF  = 15;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ex_flow_timer.sv
// Loadable down-counter with zero flag; shared by the flush and ret-timeout counts.
// Latency: load/decrement take effect on the next rising edge; zero is combinational.
// Backpressure: none; decrement saturates at zero.
module ex_flow_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    // Load wins over decrement; decrement stops at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/ex_flow_ctrl.sv
// EX-stage sequencer: flag enable plus branch/call/ret control flow, stall, redirect and flush.
// Latency: branch in EX -> redirect_o 2 cycles later; call -> 1 cycle; ret -> 1 cycle after ret_wb.
// Backpressure: stall_o holds fetch while a branch evaluates or a ret waits; instr_valid ignored when not IDLE.
module ex_flow_ctrl
    import wisc_pkg::*;
#(
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
    parameter int RET_TIMEOUT  = RET_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic instr_valid,
    input  logic sets_flags,
    input  logic branch,
    input  logic call,
    input  logic ret,
    input  logic br_taken,
    input  logic ret_wb,
    output logic alu_done,
    output logic stall_o,
    output logic flush_o,
    output logic PC_src,
    output logic redirect_o,
    output logic busy_o,
    output logic ret_timeout_o
);

    // One timer serves both counts since FLUSH and RET_WAIT never overlap.
    localparam int TMR_W = $clog2(max_int(FLUSH_CYCLES, RET_TIMEOUT) + 1);
    // Loaded with N-1 so the state lasts N cycles, leaving on the zero cycle.
    localparam logic [TMR_W-1:0] FLUSH_LOAD = TMR_W'(FLUSH_CYCLES - 1);
    localparam logic [TMR_W-1:0] RET_LOAD   = TMR_W'(RET_TIMEOUT - 1);

    ex_flow_state_t   state;
    ex_flow_state_t   state_nxt;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_load_val;
    logic             tmr_dec;
    logic             tmr_zero;
    logic             tmo_set;
    logic             stall_nxt;
    logic             flush_nxt;
    logic             redirect_nxt;
    logic             pc_src_nxt;

    ex_flow_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    // Next-state and timer control; ret > call > branch when several are set.
    always_comb begin
        state_nxt    = state;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_dec      = 1'b0;
        tmo_set      = 1'b0;
        case (state)
            IDLE: begin
                if (instr_valid && !flush_o) begin
                    if (ret) begin
                        state_nxt    = RET_WAIT;
                        tmr_load     = 1'b1;
                        tmr_load_val = RET_LOAD;
                    end else if (call) begin
                        state_nxt    = FLUSH;
                        tmr_load     = 1'b1;
                        tmr_load_val = FLUSH_LOAD;
                    end else if (branch) begin
                        state_nxt = BR_EVAL;
                    end
                end
            end
            BR_EVAL: begin
                if (br_taken) begin
                    state_nxt    = FLUSH;
                    tmr_load     = 1'b1;
                    tmr_load_val = FLUSH_LOAD;
                end else begin
                    state_nxt = IDLE;
                end
            end
            RET_WAIT: begin
                // ret_wb beats a timeout landing on the same cycle.
                if (ret_wb) begin
                    state_nxt    = FLUSH;
                    tmr_load     = 1'b1;
                    tmr_load_val = FLUSH_LOAD;
                end else if (tmr_zero) begin
                    state_nxt = IDLE;
                    tmo_set   = 1'b1;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            FLUSH: begin
                if (tmr_zero) begin
                    state_nxt = IDLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered outputs follow the upcoming state; flag enable is masked outside IDLE.
    always_comb begin
        stall_nxt    = (state_nxt == BR_EVAL) || (state_nxt == RET_WAIT);
        flush_nxt    = (state_nxt == FLUSH);
        redirect_nxt = flush_nxt && (state != FLUSH);
        pc_src_nxt   = flush_nxt;
        alu_done     = instr_valid & sets_flags & (state == IDLE) & ~flush_o;
        busy_o       = (state != IDLE);
    end

    // State and registered outputs; reset aborts any transfer without a redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            stall_o       <= 1'b0;
            flush_o       <= 1'b0;
            PC_src        <= 1'b0;
            redirect_o    <= 1'b0;
            ret_timeout_o <= 1'b0;
        end else begin
            state         <= state_nxt;
            stall_o       <= stall_nxt;
            flush_o       <= flush_nxt;
            PC_src        <= pc_src_nxt;
            redirect_o    <= redirect_nxt;
            ret_timeout_o <= ret_timeout_o | tmo_set;
        end
    end

endmodule

// File: tb/tb_ex_flow_ctrl.sv
// Directed-vector bench for ex_flow_ctrl with a per-cycle expected-output scoreboard.
// Latency: expectations are for the cycle in which the inputs are applied.
// Backpressure: n/a.
module tb_ex_flow_ctrl;

    logic clk;
    logic rst_n;
    logic instr_valid, sets_flags, branch, call, ret, br_taken, ret_wb;
    logic alu_done, stall_o, flush_o, PC_src, redirect_o, busy_o, ret_timeout_o;

    ex_flow_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_valid   (instr_valid),
        .sets_flags    (sets_flags),
        .branch        (branch),
        .call          (call),
        .ret           (ret),
        .br_taken      (br_taken),
        .ret_wb        (ret_wb),
        .alu_done      (alu_done),
        .stall_o       (stall_o),
        .flush_o       (flush_o),
        .PC_src        (PC_src),
        .redirect_o    (redirect_o),
        .busy_o        (busy_o),
        .ret_timeout_o (ret_timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs: {instr_valid, sets_flags, branch, call, ret, br_taken, ret_wb}
    localparam logic [6:0] I_NONE = 7'b0000000;
    localparam logic [6:0] I_ALU  = 7'b1100000;
    localparam logic [6:0] I_BR   = 7'b1010000;
    localparam logic [6:0] I_CALL = 7'b1001000;
    localparam logic [6:0] I_RET  = 7'b1000100;
    localparam logic [6:0] I_TK   = 7'b0000010;
    localparam logic [6:0] I_WB   = 7'b0000001;

    // Outputs: {alu_done, stall_o, flush_o, PC_src, redirect_o, busy_o, ret_timeout_o}
    localparam logic [6:0] O_ZERO  = 7'b0000000;
    localparam logic [6:0] O_ALU   = 7'b1000000;
    localparam logic [6:0] O_STALL = 7'b0100010;
    localparam logic [6:0] O_RED   = 7'b0011110;
    localparam logic [6:0] O_FL    = 7'b0011010;
    localparam logic [6:0] O_TMO   = 7'b0000001;

    logic [6:0] exp_q[$];
    string      name_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    // Apply one cycle of stimulus and queue the outputs expected during that cycle.
    task automatic cyc(input logic rst_v, input logic [6:0] in_v, input logic [6:0] exp_v,
                       input string nm);
        @(posedge clk);
        #1;
        rst_n = rst_v;
        {instr_valid, sets_flags, branch, call, ret, br_taken, ret_wb} = in_v;
        exp_q.push_back(exp_v);
        name_q.push_back(nm);
    endtask

    // Monitor: every falling edge with a pending expectation, compare all outputs.
    initial begin
        logic [6:0] act;
        logic [6:0] e;
        string      n;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                act = {alu_done, stall_o, flush_o, PC_src, redirect_o, busy_o, ret_timeout_o};
                e   = exp_q.pop_front();
                n   = name_q.pop_front();
                n_cmp++;
                if (act !== e) begin
                    n_bad++;
                    $display("FAIL %s: got alu/stall/flush/pcsrc/redir/busy/tmo=%b expected %b",
                             n, act, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        {instr_valid, sets_flags, branch, call, ret, br_taken, ret_wb} = I_NONE;
        repeat (2) @(posedge clk);

        // Reset state, then asynchronous reset in the middle of RET_WAIT.
        cyc(1'b0, I_NONE, O_ZERO, "reset_state");
        cyc(1'b1, I_RET,  O_ZERO, "rst_ret_issue");
        for (int i = 0; i < 3; i++) cyc(1'b1, I_NONE, O_STALL, "rst_ret_wait");
        cyc(1'b0, I_NONE, O_ZERO, "rst_async_clear");
        cyc(1'b0, I_WB,   O_ZERO, "rst_held");
        cyc(1'b1, I_WB,   O_ZERO, "rst_release_no_redir");
        cyc(1'b1, I_WB,   O_ZERO, "rst_release_idle");

        // ALU op then taken branch; a flag-setter in BR_EVAL must not enable flags.
        cyc(1'b1, I_ALU,         O_ALU,   "br_alu_done");
        cyc(1'b1, I_BR,          O_ZERO,  "br_issue");
        cyc(1'b1, I_ALU | I_TK,  O_STALL, "br_eval_taken");
        cyc(1'b1, I_NONE,        O_RED,   "br_redirect");
        cyc(1'b1, I_NONE,        O_FL,    "br_flush2");
        cyc(1'b1, I_NONE,        O_ZERO,  "br_exit");

        // Branch not taken.
        cyc(1'b1, I_BR,   O_ZERO,  "nt_issue");
        cyc(1'b1, I_NONE, O_STALL, "nt_eval");
        cyc(1'b1, I_NONE, O_ZERO,  "nt_idle");

        // Call; instructions arriving during flush are squashed.
        cyc(1'b1, I_CALL,        O_ZERO, "call_issue");
        cyc(1'b1, I_ALU,         O_RED,  "call_redirect");
        cyc(1'b1, I_ALU | I_BR,  O_FL,   "call_flush2");
        cyc(1'b1, I_NONE,        O_ZERO, "call_exit");

        // Priority: ret beats call and branch; call beats branch.
        cyc(1'b1, I_RET | I_CALL | I_BR, O_ZERO,  "pri_all_issue");
        cyc(1'b1, I_WB,                  O_STALL, "pri_ret_wait");
        cyc(1'b1, I_NONE,                O_RED,   "pri_ret_redirect");
        cyc(1'b1, I_NONE,                O_FL,    "pri_ret_flush2");
        cyc(1'b1, I_CALL | I_BR,         O_ZERO,  "pri_cb_issue");
        cyc(1'b1, I_NONE,                O_RED,   "pri_call_redirect");
        cyc(1'b1, I_NONE,                O_FL,    "pri_call_flush2");
        cyc(1'b1, I_NONE,                O_ZERO,  "pri_exit");

        // Ret with ret_wb in the 5th wait cycle.
        cyc(1'b1, I_RET, O_ZERO, "ret5_issue");
        for (int i = 0; i < 4; i++) cyc(1'b1, I_NONE, O_STALL, "ret5_wait");
        cyc(1'b1, I_WB,   O_STALL, "ret5_wb");
        cyc(1'b1, I_NONE, O_RED,   "ret5_redirect");
        cyc(1'b1, I_NONE, O_FL,    "ret5_flush2");
        cyc(1'b1, I_NONE, O_ZERO,  "ret5_exit");

        // ret_wb exactly on the 15th wait cycle wins over the timeout.
        cyc(1'b1, I_RET, O_ZERO, "ret15_issue");
        for (int i = 0; i < 14; i++) cyc(1'b1, I_NONE, O_STALL, "ret15_wait");
        cyc(1'b1, I_WB,   O_STALL, "ret15_wb");
        cyc(1'b1, I_NONE, O_RED,   "ret15_redirect");
        cyc(1'b1, I_NONE, O_FL,    "ret15_flush2");
        cyc(1'b1, I_NONE, O_ZERO,  "ret15_exit");

        // No ret_wb: timeout after 15 wait cycles, no redirect, late ret_wb ignored.
        cyc(1'b1, I_RET, O_ZERO, "tmo_issue");
        for (int i = 0; i < 15; i++) cyc(1'b1, I_NONE, O_STALL, "tmo_wait");
        cyc(1'b1, I_WB,   O_TMO, "tmo_set");
        cyc(1'b1, I_NONE, O_TMO, "tmo_idle");

        // Error stays sticky across later traffic until reset.
        cyc(1'b1, I_BR,   O_TMO,           "sticky_br_issue");
        cyc(1'b1, I_TK,   O_STALL | O_TMO, "sticky_br_eval");
        cyc(1'b1, I_NONE, O_RED | O_TMO,   "sticky_redirect");
        cyc(1'b1, I_NONE, O_FL | O_TMO,    "sticky_flush2");
        cyc(1'b1, I_NONE, O_TMO,           "sticky_exit");
        cyc(1'b0, I_NONE, O_ZERO,          "tmo_reset_clear");
        cyc(1'b1, I_NONE, O_ZERO,          "tmo_after_reset");

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
